alien_unit: RTL
===============

Name: alien_unit

Overview:
- Per-alien state block instantiated once per grid cell inside the alien group.
- Derives the alien's bounding box from the group origin and its row/col.
- Tracks multi-hit health, a post-hit invulnerability flash, an explosion animation and the dead state, all on frame boundaries.
- Produces pixel/active for the mixer, hittable for collision logic and a one-cycle killed pulse for scoring.

Parameters:
- CW, 12, signed coordinate width.
- ENEMY_W, 32, sprite width in pixels.
- ENEMY_H, 24, sprite height in pixels.
- SPACING_X, 16, horizontal gap between columns.
- SPACING_Y, 12, vertical gap between rows.
- HIT_POINTS, 2, hits needed to kill; must be 1..15.
- FLASH_FRAMES, 4, invulnerable flash duration in frames; must be >=1.
- EXPLODE_FRAMES, 8, explosion duration in frames; must be >=1.
- COLOR_NORMAL, 24'h00FF00, colour while alive.
- COLOR_FLASH, 24'hFFFFFF, alternate colour during flash.
- COLOR_EXPLODE, 24'hFF8000, colour while exploding.

Ports:
- pixel_clk input 1: pixel clock, the only clock.
- rst_n input 1: asynchronous, active-low reset.
- fsync input 1: one-cycle frame-start strobe.
- hpos input CW signed: current raster x.
- vpos input CW signed: current raster y.
- group_lhpos input CW signed: group left edge.
- group_tvpos input CW signed: group top edge.
- row input 4: grid row index.
- col input 4: grid column index.
- alien_hit input 1: collision strobe from the bullet logic, any cycle.
- pixel output 24: RGB for this alien, 0 when not drawing.
- active output 1: raster is inside the box and the alien is visible.
- hittable output 1: raster is inside the box and the alien is damageable.
- alien_alive output 1: alien is ALIVE or FLASH.
- killed output 1: one-cycle pulse on a lethal hit.
- lhpos, rhpos, tvpos, bvpos output CW signed each: bounding box edges.

Behaviour:
- Clock and reset: one clock, pixel_clk. rst_n is asynchronous and active-low.
- Reset values:
  - state=ALIVE, hp=HIT_POINTS, frame_cnt=0, hit_pending=0, killed=0.
  - Combinational outputs follow from these values.
  - Reset asserted mid-flash or mid-explosion returns the alien to ALIVE at full hp.
- Bounding box (combinational):
  - lhpos = group_lhpos + col*(ENEMY_W+SPACING_X).
  - rhpos = lhpos + ENEMY_W - 1.
  - tvpos = group_tvpos + row*(ENEMY_H+SPACING_Y).
  - bvpos = tvpos + ENEMY_H - 1.
  - Products are zero-extended to CW. Sums wrap modulo 2^CW.
  - in_box uses signed, inclusive compares on all four edges.
- States: ALIVE, FLASH, EXPLODE, DEAD.
- hit_pending:
  - Set on alien_hit while state==ALIVE.
  - Ignored in FLASH, EXPLODE and DEAD.
  - Cleared on every fsync.
  - Multiple hits within one frame count as one.
- Damage is applied on the fsync cycle when (hit_pending | alien_hit) and state==ALIVE. A hit coincident with fsync counts.
  - If hp==1: hp<=0, state<=EXPLODE, frame_cnt<=0, killed<=1 for exactly one cycle (the cycle after fsync).
  - Otherwise: hp<=hp-1, state<=FLASH, frame_cnt<=0.
- FLASH:
  - Each fsync increments frame_cnt.
  - At fsync with frame_cnt==FLASH_FRAMES-1: state<=ALIVE, frame_cnt<=0.
  - A hit is never applied on the exit fsync.
- EXPLODE:
  - Same counting with EXPLODE_FRAMES.
  - Exits to DEAD.
- DEAD: terminal until reset.
- Combinational outputs:
  - active = in_box && state!=DEAD.
  - hittable = in_box && state==ALIVE.
  - alien_alive = state∈{ALIVE,FLASH}.
  - pixel = 0 when !active. Otherwise: ALIVE → COLOR_NORMAL; FLASH → COLOR_FLASH if frame_cnt[0] else COLOR_NORMAL; EXPLODE → COLOR_EXPLODE.
- Counter widths:
  - frame_cnt width is clog2(max(FLASH_FRAMES,EXPLODE_FRAMES)+1).
  - hp width is 4.
  - Neither counter wraps in legal operation.
- Degenerate case: HIT_POINTS=1 means the first hit goes straight to EXPLODE.

Decomposition:
- Shared package gains the following, reused by the group and the collision logic:
  - alien_state_t enum {ALIVE, FLASH, EXPLODE, DEAD}.
  - ENEMY_W/H, SPACING_X/Y and the colour constants as package defaults.
  - A function box_hit(h, v, l, r, t, b).
- One sub-module, frame_timer: counts fsync pulses up to a load value and raises done on the terminal fsync. The FSM uses it for both FLASH and EXPLODE.

Test Plan:
- Reset, group=(100,50), row=1, col=2: lhpos=196, rhpos=227, tvpos=86, bvpos=109. Raster at (196,86) → active=1, hittable=1, pixel=00FF00. At (228,86) → active=0, pixel=0.
- HIT_POINTS=2, alien_hit mid-frame then fsync: state=FLASH, hp=1. Pixel alternates FFFFFF/00FF00 on successive frames. ALIVE again after 4 fsyncs. No killed pulse.
- Hit during FLASH: hp stays 1, hittable=0. The next hit after return to ALIVE → EXPLODE and killed high exactly 1 cycle. Pixel FF8000 for 8 frames, then DEAD with active=0 and pixel=0.
- alien_hit coincident with fsync, HIT_POINTS=1: EXPLODE entered on that fsync. Three hits in one frame on a HIT_POINTS=3 alien decrement hp by exactly 1.
- rst_n asserted asynchronously mid-EXPLODE (no clock edge): outputs return immediately to ALIVE, hp=HIT_POINTS, killed=0.
- Negative group_lhpos=-40, col=0: lhpos=-40, rhpos=-9. hpos=0 → active=0. Signed compare is correct with no wrap artefact.

Source files
------------

// File: rtl/alien_unit_pkg.sv
// alien_unit_pkg: shared alien state type, geometry/colour defaults and hit-box test
//   alien_state_t : ALIVE, FLASH, EXPLODE, DEAD
//   *_DEF         : default sprite size, grid spacing and colours
//   box_hit()     : signed inclusive point-in-rectangle test
package alien_unit_pkg;

   typedef enum logic [1:0] {ALIVE, FLASH, EXPLODE, DEAD} alien_state_t;

   localparam int          ENEMY_W_DEF       = 32;
   localparam int          ENEMY_H_DEF       = 24;
   localparam int          SPACING_X_DEF     = 16;
   localparam int          SPACING_Y_DEF     = 12;
   localparam logic [23:0] COLOR_NORMAL_DEF  = 24'h00FF00;
   localparam logic [23:0] COLOR_FLASH_DEF   = 24'hFFFFFF;
   localparam logic [23:0] COLOR_EXPLODE_DEF = 24'hFF8000;

   // Callers sign-extend their coordinates to 32 bits so one function serves any width.
   function automatic logic box_hit(input logic signed [31:0] h, v, l, r, t, b);
      return (h >= l) && (h <= r) && (v >= t) && (v <= b);
   endfunction

endpackage

// File: rtl/alien_unit_frame_timer.sv
// alien_unit_frame_timer: counts frame ticks from zero up to a terminal value
//   clk, rst_n : clock, asynchronous active-low reset
//   start_i    : restart the count at zero (has priority over tick_i)
//   tick_i     : one frame elapsed (fsync qualified by the caller)
//   last_i     : terminal count; the tick seen at this count raises done_o
//   odd_o      : low bit of the count, used for the flash blink phase
//   done_o     : combinational, high on the terminal tick; the count then returns to zero
module alien_unit_frame_timer #(
   parameter int W = 4
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         start_i,
   input  logic         tick_i,
   input  logic [W-1:0] last_i,
   output logic         odd_o,
   output logic         done_o
);

   logic [W-1:0] cnt_q, cnt_d;

   assign done_o = tick_i && !start_i && cnt_q == last_i;
   assign odd_o  = cnt_q[0];

   always_comb cnt_d = (start_i || done_o) ? '0 : tick_i ? cnt_q + W'(1) : cnt_q;

   always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) cnt_q <= '0;
      else        cnt_q <= cnt_d;

endmodule

// File: rtl/alien_unit.sv
// alien_unit: per-alien bounding box, health, flash/explosion timing and pixel output
//   pixel_clk, rst_n            : clock, asynchronous active-low reset
//   fsync                       : one-cycle frame-start strobe
//   hpos, vpos                  : current raster position (signed)
//   group_lhpos, group_tvpos    : group origin (signed)
//   row, col                    : grid cell of this alien
//   alien_hit                   : collision strobe, any cycle
//   pixel, active               : colour and visibility at the raster position
//   hittable                    : raster inside box and alien can take damage
//   alien_alive                 : ALIVE or FLASH
//   killed                      : one-cycle pulse after a lethal fsync
//   lhpos, rhpos, tvpos, bvpos  : bounding box edges (signed)
module alien_unit
   import alien_unit_pkg::*;
#(
   parameter int          CW             = 12,
   parameter int          ENEMY_W        = ENEMY_W_DEF,
   parameter int          ENEMY_H        = ENEMY_H_DEF,
   parameter int          SPACING_X      = SPACING_X_DEF,
   parameter int          SPACING_Y      = SPACING_Y_DEF,
   parameter int          HIT_POINTS     = 2,
   parameter int          FLASH_FRAMES   = 4,
   parameter int          EXPLODE_FRAMES = 8,
   parameter logic [23:0] COLOR_NORMAL   = COLOR_NORMAL_DEF,
   parameter logic [23:0] COLOR_FLASH    = COLOR_FLASH_DEF,
   parameter logic [23:0] COLOR_EXPLODE  = COLOR_EXPLODE_DEF
) (
   input  logic                 pixel_clk,
   input  logic                 rst_n,
   input  logic                 fsync,
   input  logic signed [CW-1:0] hpos,
   input  logic signed [CW-1:0] vpos,
   input  logic signed [CW-1:0] group_lhpos,
   input  logic signed [CW-1:0] group_tvpos,
   input  logic [3:0]           row,
   input  logic [3:0]           col,
   input  logic                 alien_hit,
   output logic [23:0]          pixel,
   output logic                 active,
   output logic                 hittable,
   output logic                 alien_alive,
   output logic                 killed,
   output logic signed [CW-1:0] lhpos,
   output logic signed [CW-1:0] rhpos,
   output logic signed [CW-1:0] tvpos,
   output logic signed [CW-1:0] bvpos
);

   localparam int            FMAX   = FLASH_FRAMES > EXPLODE_FRAMES ? FLASH_FRAMES : EXPLODE_FRAMES;
   localparam int            FW     = $clog2(FMAX + 1);
   localparam logic [CW-1:0] STEP_X = CW'(ENEMY_W + SPACING_X);
   localparam logic [CW-1:0] STEP_Y = CW'(ENEMY_H + SPACING_Y);

   if (HIT_POINTS < 1 || HIT_POINTS > 15) begin : g_bad_hp
      $error("alien_unit: HIT_POINTS must be 1..15");
   end
   if (FLASH_FRAMES < 1 || EXPLODE_FRAMES < 1) begin : g_bad_frames
      $error("alien_unit: FLASH_FRAMES and EXPLODE_FRAMES must be >= 1");
   end

   alien_state_t  state_q, state_d;
   logic [3:0]    hp_q, hp_d;
   logic          pend_q, pend_d;
   logic          killed_q, killed_d;
   logic [CW-1:0] off_x, off_y;
   logic [FW-1:0] last;
   logic          in_box, damage, lethal, tick, done, odd;

   // Grid offsets are unsigned products; the sums wrap modulo 2^CW.
   assign off_x = CW'(col) * STEP_X;
   assign off_y = CW'(row) * STEP_Y;
   assign lhpos = group_lhpos + $signed(off_x);
   assign tvpos = group_tvpos + $signed(off_y);
   assign rhpos = lhpos + $signed(CW'(ENEMY_W - 1));
   assign bvpos = tvpos + $signed(CW'(ENEMY_H - 1));
   assign in_box = box_hit(32'(hpos), 32'(vpos), 32'(lhpos), 32'(rhpos), 32'(tvpos), 32'(bvpos));

   // A hit latched earlier in the frame or arriving on the fsync itself both count once.
   assign damage = fsync && state_q == ALIVE && (pend_q || alien_hit);
   assign lethal = damage && hp_q == 4'd1;
   assign tick   = fsync && (state_q == FLASH || state_q == EXPLODE);
   assign last   = state_q == FLASH ? FW'(FLASH_FRAMES - 1) : FW'(EXPLODE_FRAMES - 1);

   alien_unit_frame_timer #(.W(FW)) u_timer (
      .clk     (pixel_clk),
      .rst_n   (rst_n),
      .start_i (damage),
      .tick_i  (tick),
      .last_i  (last),
      .odd_o   (odd),
      .done_o  (done)
   );

   always_comb begin
      state_d  = state_q;
      hp_d     = hp_q;
      killed_d = lethal;
      pend_d   = fsync ? 1'b0 : (pend_q || (alien_hit && state_q == ALIVE));
      if (damage) begin
         hp_d    = hp_q - 4'd1;
         state_d = lethal ? EXPLODE : FLASH;
      end else if (done) begin
         state_d = state_q == FLASH ? ALIVE : DEAD;
      end
   end

   always_ff @(posedge pixel_clk or negedge rst_n)
      if (!rst_n) begin
         state_q  <= ALIVE;
         hp_q     <= 4'(HIT_POINTS);
         pend_q   <= 1'b0;
         killed_q <= 1'b0;
      end else begin
         state_q  <= state_d;
         hp_q     <= hp_d;
         pend_q   <= pend_d;
         killed_q <= killed_d;
      end

   assign active      = in_box && state_q != DEAD;
   assign hittable    = in_box && state_q == ALIVE;
   assign alien_alive = state_q == ALIVE || state_q == FLASH;
   assign killed      = killed_q;
   assign pixel       = !active                   ? 24'h0 :
                        state_q == EXPLODE        ? COLOR_EXPLODE :
                        (state_q == FLASH && odd) ? COLOR_FLASH : COLOR_NORMAL;

endmodule
